// File: rtl/axi_llc_cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_cfg_seq_pkg
// Brief    : Register offsets, command opcodes and sequencer states shared by
//            the LLC configuration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package axi_llc_cfg_seq_pkg;

    localparam logic [31:0] c_off_cfg_spm   = 32'h0000_0000;
    localparam logic [31:0] c_off_cfg_flush = 32'h0000_0008;
    localparam logic [31:0] c_off_commit    = 32'h0000_0010;
    localparam logic [31:0] c_off_flushed   = 32'h0000_0018;

    typedef enum logic {
        OP_FLUSH   = 1'b0,
        OP_SET_SPM = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_FLUSH   = 3'd1,
        S_WR_COMMIT1 = 3'd2,
        S_POLL_RD    = 3'd3,
        S_POLL_WAIT  = 3'd4,
        S_WR_SPM     = 3'd5,
        S_WR_COMMIT2 = 3'd6,
        S_RESP       = 3'd7
    } state_e;

endpackage
`default_nettype wire

// File: rtl/axi_llc_cfg_seq_regbus_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_cfg_seq_regbus_if
// Brief    : Holds one RegBus request (valid + payload) stable until the
//            slave signals ready.
// Revision : 1.0 - initial release
// ============================================================================
module axi_llc_cfg_seq_regbus_if (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_issue,
    input  logic [31:0] i_addr,
    input  logic        i_write,
    input  logic [31:0] i_wdata,
    input  logic        i_resp_ready,
    output logic        o_done,
    output logic        o_req_valid,
    output logic [31:0] o_req_addr,
    output logic        o_req_write,
    output logic [31:0] o_req_wdata,
    output logic [3:0]  o_req_wstrb
);

    logic        r_valid;
    logic [31:0] r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    assign o_done = r_valid & i_resp_ready;

    // A new request may be loaded in the same cycle the previous one completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (i_issue) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_write <= i_write;
            r_wdata <= i_write ? i_wdata : 32'h0;
            r_wstrb <= i_write ? 4'hF : 4'h0;
        end else if (o_done) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end
    end

    assign o_req_valid = r_valid;
    assign o_req_addr  = r_addr;
    assign o_req_write = r_write;
    assign o_req_wdata = r_wdata;
    assign o_req_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: rtl/axi_llc_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_cfg_sequencer
// Brief    : Turns flush / set-SPM commands into ordered LLC config register
//            writes, commits and FLUSHED polling on the RegBus.
// Revision : 1.0 - initial release
// ============================================================================
module axi_llc_cfg_sequencer
    import axi_llc_cfg_seq_pkg::*;
#(
    parameter int          SET_ASSOCIATIVITY = 8,
    parameter logic [31:0] REG_BASE          = 32'h0,
    parameter int          POLL_GAP          = 16,
    parameter int          MAX_POLLS         = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic                         cmd_op_i,
    input  logic [SET_ASSOCIATIVITY-1:0] cmd_mask_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic                         rsp_err_o,
    output logic [SET_ASSOCIATIVITY-1:0] spm_mask_o,
    output logic                         busy_o,
    output logic [31:0]                  conf_req_addr_o,
    output logic                         conf_req_w_o,
    output logic [31:0]                  conf_req_wdata_o,
    output logic [3:0]                   conf_req_wstrb_o,
    output logic                         conf_req_valid_o,
    input  logic [31:0]                  conf_resp_rdata_i,
    input  logic                         conf_resp_error_i,
    input  logic                         conf_resp_ready_i
);

    localparam int c_sa     = SET_ASSOCIATIVITY;
    localparam int c_poll_w = $clog2(MAX_POLLS + 1);
    localparam int c_gap_w  = $clog2(POLL_GAP + 1);
    localparam logic [c_poll_w-1:0] c_max_polls = c_poll_w'(MAX_POLLS);
    localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'(POLL_GAP - 1);

    state_e              r_state,      w_state_nxt;
    op_e                 r_op,         w_op_nxt;
    logic [c_sa-1:0]     r_cmd_mask,   w_cmd_mask_nxt;
    logic [c_sa-1:0]     r_flush_mask, w_flush_mask_nxt;
    logic [c_sa-1:0]     r_spm_mask,   w_spm_mask_nxt;
    logic [c_poll_w-1:0] r_poll_cnt,   w_poll_cnt_nxt;
    logic [c_gap_w-1:0]  r_gap_cnt,    w_gap_cnt_nxt;
    logic                r_rsp_valid,  w_rsp_valid_nxt;
    logic                r_rsp_err,    w_rsp_err_nxt;

    logic                w_issue;
    logic [31:0]         w_req_addr;
    logic                w_req_write;
    logic [31:0]         w_req_wdata;
    logic                w_done;
    logic [c_sa-1:0]     w_cmd_flush;
    logic                w_rd_hit;
    logic [c_poll_w-1:0] w_poll_inc;

    function automatic logic [31:0] widen(input logic [c_sa-1:0] m);
        widen = '0;
        widen[c_sa-1:0] = m;
    endfunction

    // SET_SPM only has to flush the ways that newly enter scratchpad mode.
    assign w_cmd_flush = (op_e'(cmd_op_i) == OP_FLUSH) ? cmd_mask_i
                                                       : (cmd_mask_i & ~r_spm_mask);
    assign w_rd_hit    = ((conf_resp_rdata_i[c_sa-1:0] & r_flush_mask) == r_flush_mask);
    assign w_poll_inc  = r_poll_cnt + c_poll_w'(1);

    generate
        if (c_sa < 32) begin : g_rdata_unused
            logic w_unused_rdata;
            assign w_unused_rdata = ^conf_resp_rdata_i[31:c_sa];
        end
    endgenerate

    always_comb begin
        w_state_nxt      = r_state;
        w_op_nxt         = r_op;
        w_cmd_mask_nxt   = r_cmd_mask;
        w_flush_mask_nxt = r_flush_mask;
        w_spm_mask_nxt   = r_spm_mask;
        w_poll_cnt_nxt   = r_poll_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_err_nxt    = r_rsp_err;
        w_issue          = 1'b0;
        w_req_addr       = '0;
        w_req_write      = 1'b0;
        w_req_wdata      = '0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_op_nxt         = op_e'(cmd_op_i);
                    w_cmd_mask_nxt   = cmd_mask_i;
                    w_flush_mask_nxt = w_cmd_flush;
                    w_poll_cnt_nxt   = '0;
                    w_gap_cnt_nxt    = '0;
                    w_rsp_err_nxt    = 1'b0;
                    if (w_cmd_flush != '0) begin
                        w_state_nxt = S_WR_FLUSH;
                        w_issue     = 1'b1;
                        w_req_addr  = REG_BASE + c_off_cfg_flush;
                        w_req_write = 1'b1;
                        w_req_wdata = widen(w_cmd_flush);
                    end else if (op_e'(cmd_op_i) == OP_SET_SPM) begin
                        w_state_nxt = S_WR_SPM;
                        w_issue     = 1'b1;
                        w_req_addr  = REG_BASE + c_off_cfg_spm;
                        w_req_write = 1'b1;
                        w_req_wdata = widen(cmd_mask_i);
                    end else begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                    end
                end
            end
            S_WR_FLUSH: begin
                if (w_done) begin
                    w_state_nxt = S_WR_COMMIT1;
                    w_issue     = 1'b1;
                    w_req_addr  = REG_BASE + c_off_commit;
                    w_req_write = 1'b1;
                    w_req_wdata = 32'h1;
                end
            end
            S_WR_COMMIT1: begin
                if (w_done) begin
                    w_state_nxt = S_POLL_RD;
                    w_issue     = 1'b1;
                    w_req_addr  = REG_BASE + c_off_flushed;
                end
            end
            S_POLL_RD: begin
                if (w_done) begin
                    w_poll_cnt_nxt = w_poll_inc;
                    if (w_rd_hit && (r_op == OP_SET_SPM)) begin
                        w_state_nxt = S_WR_SPM;
                        w_issue     = 1'b1;
                        w_req_addr  = REG_BASE + c_off_cfg_spm;
                        w_req_write = 1'b1;
                        w_req_wdata = widen(r_cmd_mask);
                    end else if (w_rd_hit) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                    end else if (w_poll_inc == c_max_polls) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt   = S_POLL_WAIT;
                        w_gap_cnt_nxt = '0;
                    end
                end
            end
            S_POLL_WAIT: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt   = S_POLL_RD;
                    w_gap_cnt_nxt = '0;
                    w_issue       = 1'b1;
                    w_req_addr    = REG_BASE + c_off_flushed;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + c_gap_w'(1);
                end
            end
            S_WR_SPM: begin
                if (w_done) begin
                    w_state_nxt = S_WR_COMMIT2;
                    w_issue     = 1'b1;
                    w_req_addr  = REG_BASE + c_off_commit;
                    w_req_write = 1'b1;
                    w_req_wdata = 32'h1;
                end
            end
            S_WR_COMMIT2: begin
                if (w_done) begin
                    w_state_nxt     = S_RESP;
                    w_spm_mask_nxt  = r_cmd_mask;
                    w_rsp_valid_nxt = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A slave error on any transfer abandons the rest of the sequence.
        if (w_done && conf_resp_error_i) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_spm_mask_nxt  = r_spm_mask;
            w_issue         = 1'b0;
            w_req_addr      = '0;
            w_req_write     = 1'b0;
            w_req_wdata     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_op         <= OP_FLUSH;
            r_cmd_mask   <= '0;
            r_flush_mask <= '0;
            r_spm_mask   <= '0;
            r_poll_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_cmd_mask   <= w_cmd_mask_nxt;
            r_flush_mask <= w_flush_mask_nxt;
            r_spm_mask   <= w_spm_mask_nxt;
            r_poll_cnt   <= w_poll_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
        end
    end

    axi_llc_cfg_seq_regbus_if u_regbus (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_issue      (w_issue),
        .i_addr       (w_req_addr),
        .i_write      (w_req_write),
        .i_wdata      (w_req_wdata),
        .i_resp_ready (conf_resp_ready_i),
        .o_done       (w_done),
        .o_req_valid  (conf_req_valid_o),
        .o_req_addr   (conf_req_addr_o),
        .o_req_write  (conf_req_w_o),
        .o_req_wdata  (conf_req_wdata_o),
        .o_req_wstrb  (conf_req_wstrb_o)
    );

    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign spm_mask_o  = r_spm_mask;

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_llc_cfg_sequencer
// Brief    : Directed bench for the LLC config sequencer with a RegBus slave
//            model whose ready delay, FLUSHED data and error are adjustable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_llc_cfg_sequencer;

    localparam int c_sa = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready_o;
    logic              cmd_op = 1'b0;
    logic [c_sa-1:0]   cmd_mask = '0;
    logic              rsp_valid_o;
    logic              rsp_ready = 1'b0;
    logic              rsp_err_o;
    logic [c_sa-1:0]   spm_mask_o;
    logic              busy_o;
    logic [31:0]       conf_req_addr_o;
    logic              conf_req_w_o;
    logic [31:0]       conf_req_wdata_o;
    logic [3:0]        conf_req_wstrb_o;
    logic              conf_req_valid_o;
    logic [31:0]       conf_resp_rdata_i = '0;
    logic              conf_resp_error_i = 1'b0;
    logic              conf_resp_ready_i = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Slave model state
    int          delay     = 0;
    int          wait_cnt  = 0;
    int          rd_count  = 0;
    int          match_on  = 1;
    logic [31:0] match_val = 32'hFF;
    logic        err_en    = 1'b0;
    logic [31:0] err_addr  = 32'h0;
    logic [79:0] log_q[$];
    int          log_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_llc_cfg_sequencer #(
        .SET_ASSOCIATIVITY (c_sa),
        .REG_BASE          (32'h0),
        .POLL_GAP          (4),
        .MAX_POLLS         (8)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_op_i          (cmd_op),
        .cmd_mask_i        (cmd_mask),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready),
        .rsp_err_o         (rsp_err_o),
        .spm_mask_o        (spm_mask_o),
        .busy_o            (busy_o),
        .conf_req_addr_o   (conf_req_addr_o),
        .conf_req_w_o      (conf_req_w_o),
        .conf_req_wdata_o  (conf_req_wdata_o),
        .conf_req_wstrb_o  (conf_req_wstrb_o),
        .conf_req_valid_o  (conf_req_valid_o),
        .conf_resp_rdata_i (conf_resp_rdata_i),
        .conf_resp_error_i (conf_resp_error_i),
        .conf_resp_ready_i (conf_resp_ready_i)
    );

    // Slave: decides ready for the coming rising edge; logs each completing transfer.
    always @(negedge clk) begin
        if (conf_resp_ready_i) begin
            conf_resp_ready_i = 1'b0;
            conf_resp_error_i = 1'b0;
            wait_cnt = 0;
        end
        if (conf_req_valid_o) begin
            if (wait_cnt >= delay) begin
                conf_resp_ready_i = 1'b1;
                conf_resp_error_i = err_en && (conf_req_addr_o == err_addr);
                if (!conf_req_w_o) begin
                    rd_count++;
                    conf_resp_rdata_i = (rd_count >= match_on) ? match_val : 32'h0;
                end
                log_q.push_back({11'b0, conf_req_w_o, conf_req_wstrb_o, conf_req_addr_o,
                                 conf_req_w_o ? conf_req_wdata_o : 32'h0});
                log_cyc.push_back(cyc);
            end else begin
                wait_cnt++;
            end
        end
    end

    function automatic logic [79:0] wr(input logic [31:0] a, input logic [31:0] d);
        return {11'b0, 1'b1, 4'hF, a, d};
    endfunction

    function automatic logic [79:0] rd(input logic [31:0] a);
        return {11'b0, 1'b0, 4'h0, a, 32'h0};
    endfunction

    function automatic logic [79:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return '1;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < log_cyc.size()) return log_cyc[i];
        return -100;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_q.delete();
        log_cyc.delete();
        rd_count = 0;
    endtask

    task automatic send_cmd(input logic op, input logic [c_sa-1:0] mask);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        n = 0;
        while (!cmd_ready_o && n < 200) begin
            step();
            n++;
        end
        check("cmd_ready_wait", cmd_ready_o, 1'b1);
        step();
        cmd_valid = 1'b0;
        cmd_mask  = '0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid_o && n < 2000) begin
            step();
            n++;
        end
        check("rsp_valid_wait", rsp_valid_o, 1'b1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int n;
        int sz;

        // Reset state
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        check("rst_cmd_ready", cmd_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_req", {conf_req_valid_o, conf_req_w_o, conf_req_wstrb_o, conf_req_addr_o, conf_req_wdata_o}, '0);
        check("rst_rsp", {rsp_valid_o, rsp_err_o}, 2'b00);
        check("rst_spm", spm_mask_o, 8'h00);

        // 1: flush 0x0F, FLUSHED matches on 3rd read
        clear_log();
        delay = 0; match_on = 3; match_val = 32'h0F;
        send_cmd(1'b0, 8'h0F);
        wait_rsp();
        check("t1_err", rsp_err_o, 1'b0);
        check("t1_cmd_ready_in_resp", cmd_ready_o, 1'b0);
        check("t1_nlog", log_q.size(), 5);
        check("t1_wr_flush", log_at(0), wr(32'h08, 32'h0F));
        check("t1_wr_commit", log_at(1), wr(32'h10, 32'h1));
        check("t1_rd0", log_at(2), rd(32'h18));
        check("t1_rd1", log_at(3), rd(32'h18));
        check("t1_rd2", log_at(4), rd(32'h18));
        check("t1_gap01", cyc_at(3) - cyc_at(2), 5);
        check("t1_gap12", cyc_at(4) - cyc_at(3), 5);
        check("t1_rsp_latency", cyc, cyc_at(4) + 1);
        ack();
        check("t1_idle_after_ack", {cmd_ready_o, rsp_valid_o, busy_o}, 3'b100);

        // 2: SET_SPM 0x03 from empty, then SET_SPM 0x01 (no flush needed)
        clear_log();
        match_on = 1; match_val = 32'hFF;
        send_cmd(1'b1, 8'h03);
        wait_rsp();
        check("t2a_err", rsp_err_o, 1'b0);
        check("t2a_nlog", log_q.size(), 5);
        check("t2a_wr_flush", log_at(0), wr(32'h08, 32'h03));
        check("t2a_wr_commit1", log_at(1), wr(32'h10, 32'h1));
        check("t2a_rd", log_at(2), rd(32'h18));
        check("t2a_wr_spm", log_at(3), wr(32'h00, 32'h03));
        check("t2a_wr_commit2", log_at(4), wr(32'h10, 32'h1));
        check("t2a_spm", spm_mask_o, 8'h03);
        ack();
        clear_log();
        send_cmd(1'b1, 8'h01);
        wait_rsp();
        check("t2b_nlog", log_q.size(), 2);
        check("t2b_wr_spm", log_at(0), wr(32'h00, 32'h01));
        check("t2b_wr_commit", log_at(1), wr(32'h10, 32'h1));
        check("t2b_spm", spm_mask_o, 8'h01);
        ack();

        // 3: FLUSHED never matches -> timeout after 8 reads
        clear_log();
        match_on = 1000;
        send_cmd(1'b0, 8'hF0);
        wait_rsp();
        check("t3_err", rsp_err_o, 1'b1);
        check("t3_reads", rd_count, 8);
        check("t3_nlog", log_q.size(), 10);
        check("t3_wr_flush", log_at(0), wr(32'h08, 32'hF0));
        check("t3_last_rd", log_at(9), rd(32'h18));
        check("t3_spm", spm_mask_o, 8'h01);
        step(3);
        check("t3_no_more_traffic", log_q.size(), 10);
        ack();

        // 4: slave error on first COMMIT
        clear_log();
        match_on = 1; err_en = 1'b1; err_addr = 32'h10;
        send_cmd(1'b1, 8'h0C);
        wait_rsp();
        check("t4_err", rsp_err_o, 1'b1);
        check("t4_rsp_latency", cyc, cyc_at(1) + 1);
        check("t4_nlog", log_q.size(), 2);
        check("t4_wr_flush", log_at(0), wr(32'h08, 32'h0C));
        check("t4_spm", spm_mask_o, 8'h01);
        ack();
        err_en = 1'b0;

        // 5: slave ready delayed 5 cycles; response held 3 cycles
        clear_log();
        delay = 5;
        send_cmd(1'b0, 8'h01);
        for (int i = 0; i < 6; i++) begin
            check("t5_stable", {conf_req_valid_o, conf_req_w_o, conf_req_addr_o, conf_req_wdata_o},
                  {1'b1, 1'b1, 32'h08, 32'h01});
            step();
        end
        check("t5_next_req", {conf_req_valid_o, conf_req_addr_o}, {1'b1, 32'h10});
        wait_rsp();
        for (int i = 0; i < 3; i++) begin
            check("t5_rsp_held", {rsp_valid_o, cmd_ready_o}, 2'b10);
            step();
        end
        ack();
        check("t5_after_ack", {rsp_valid_o, cmd_ready_o}, 2'b01);
        check("t5_nlog", log_q.size(), 3);
        delay = 0;

        // 6: reset during POLL_WAIT, then empty flush
        clear_log();
        match_on = 1000;
        send_cmd(1'b0, 8'h02);
        n = 0;
        while (rd_count < 1 && n < 200) begin
            step();
            n++;
        end
        check("t6_reached_poll", rd_count, 1);
        check("t6_in_wait", {busy_o, conf_req_valid_o}, 2'b10);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_idle", {cmd_ready_o, busy_o, conf_req_valid_o, rsp_valid_o}, 4'b1000);
        check("t6_rst_spm", spm_mask_o, 8'h00);
        sz = log_q.size();
        step(3);
        check("t6_no_rsp", rsp_valid_o, 1'b0);
        send_cmd(1'b0, 8'h00);
        check("t6_empty_rsp_1cyc", {rsp_valid_o, rsp_err_o}, 2'b10);
        ack();
        check("t6_no_bus", log_q.size(), sz);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
